uart_ack_framer: RTL
====================

UART_ACK_FRAMER -- requirements
Module: uart_ack_framer

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'h80: first byte of every ack frame.
REQ-002 SHALL have parameter TAIL_BYTE, default 8'h55: last byte of every ack frame.
REQ-003 SHALL have parameter START_DLY, default 16: clk_50M cycles from request acceptance to first byte load; legal range 4..255.
REQ-004 SHALL have parameter GAP_CYC, default 15: idle cycles inserted after each tx_done before the next byte load; legal range 0..255.
REQ-005 SHALL have port clk_50M, input, 1: sole clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port recv_done, input, 1: one-cycle pulse marking a received command packet.
REQ-008 SHALL have ports rev_data1, rev_data2, rev_data3, input, 8 each: payload echoed in the ack.
REQ-009 SHALL have port tx_busy, input, 1: UART transmitter busy.
REQ-010 SHALL have port tx_done, input, 1: one-cycle pulse, byte fully shifted out.
REQ-011 SHALL have port tx_en, output, 1: one-cycle start strobe to the transmitter.
REQ-012 SHALL have port tx_data, output, 8: byte to transmit.
REQ-013 SHALL have port ack_busy, output, 1: high from request acceptance until the frame completes.
REQ-014 SHALL have port ack_done, output, 1: one-cycle pulse after the sixth tx_done and its gap.
REQ-015 SHALL have port ack_drop, output, 1: one-cycle pulse when a request is discarded.

Function
REQ-016 Frame SHALL be six bytes in order: HDR_BYTE, byte1, byte2, byte3, check byte, TAIL_BYTE.
REQ-017 In IDLE, recv_done SHALL snapshot rev_data1..3 into internal registers and move to DELAY; ack_busy rises on the following cycle.
REQ-018 DELAY SHALL last exactly START_DLY cycles, then enter LOAD with byte index 0.
REQ-019 In LOAD, when tx_busy is low, SHALL register tx_data = frame[index], pulse tx_en for one cycle, and enter WAIT_DONE; while tx_busy is high, SHALL remain in LOAD with tx_en low.
REQ-020 tx_data SHALL stay stable from the tx_en cycle until the matching tx_done.
REQ-021 In WAIT_DONE, tx_done SHALL move to GAP; a GAP_CYC counter runs, and GAP_CYC=0 leaves GAP on the next cycle.
REQ-022 On leaving GAP: index<5 -> increment index, go to LOAD; index==5 -> FINISH, pulse ack_done, clear ack_busy, go to IDLE.
REQ-023 tx_done outside WAIT_DONE SHALL be ignored.
REQ-024 recv_done while not IDLE SHALL be stored in a one-deep pending slot with its own rev_data1..3 snapshot; if the slot is already full, the request is discarded and ack_drop pulses.
REQ-025 On reaching IDLE with the pending slot full, SHALL start that frame on the next cycle (slot data moved to active snapshot, slot cleared); recv_done arriving in the same cycle fills the freed slot.
REQ-026 The index counter SHALL be 3 bits; values 6..7 are unreachable and, if reached, return to IDLE.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, index 0, counters 0, pending slot empty, tx_en=0, tx_data=8'h00, ack_busy=0, ack_done=0, ack_drop=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no further tx_en; after release, the first recv_done starts a fresh frame.

Configuration
REQ-029 With ACK_CRC_EN defined, the check byte SHALL be CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over byte1..byte3, computed one byte per cycle during the first three DELAY cycles.
REQ-030 Without ACK_CRC_EN, the check byte SHALL be constant 8'h11 and no CRC logic is instantiated.

Structure
REQ-031 State encodings (IDLE, DELAY, LOAD, WAIT_DONE, GAP, FINISH), the frame length of 6 and the default constant 8'h11 SHALL live in the shared package dds_uart_pkg.
REQ-032 CRC SHALL be a sub-module crc8_byte (clear, enable, data_in[7:0], crc_out[7:0]), instantiated only under ACK_CRC_EN.

Verification
REQ-033 ACK_CRC_EN defined, rev_data=01,02,03, recv_done pulse -> tx_data sequence 80,01,02,03,48,55 on six tx_en pulses; then ack_done.
REQ-034 ACK_CRC_EN undefined, same stimulus -> 80,01,02,03,11,55.
REQ-035 tx_busy held high for 100 cycles on entering LOAD -> no tx_en until first cycle after tx_busy falls; first tx_en at START_DLY+1 cycles after recv_done when tx_busy is low.
REQ-036 Second recv_done (AA,BB,CC) mid-frame, third mid-frame -> frame 2 carries AA,BB,CC and starts one cycle after frame 1 ack_done; third causes one ack_drop pulse.
REQ-037 rst_n asserted after the third tx_en -> tx_en, ack_busy low immediately; no further tx_en; a new recv_done yields a complete correct frame.
REQ-038 GAP_CYC=15 -> tx_en of byte n+1 occurs exactly 17 cycles after tx_done of byte n with tx_busy low.

Source files
------------

// File: rtl/dds_uart_pkg.sv
// dds_uart_pkg
// Shared definitions for the UART ack framer: FSM state encodings, the ack
// frame length, the fixed check byte used when the CRC build option
// (ACK_CRC_EN) is off, and a helper that picks a frame byte by index.
// No ports; imported by uart_ack_framer.
package dds_uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DELAY     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  localparam int FRAME_LEN = 6;

  localparam logic [7:0] CHK_DEFAULT = 8'h11;

  // Frame order: header, three payload bytes, check byte, tail.
  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic [7:0] hdr,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic [7:0] chk,
    input logic [7:0] tail
  );
    logic [7:0] res;
    res = 8'h00;
    case (idx)
      3'd0:    res = hdr;
      3'd1:    res = b1;
      3'd2:    res = b2;
      3'd3:    res = b3;
      3'd4:    res = chk;
      3'd5:    res = tail;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/crc8_byte.sv
// crc8_byte
// Byte-wide CRC-8 accumulator: polynomial 0x07, init 0x00, MSB-first, no
// reflection, no final XOR. One byte is folded in per enabled cycle.
// Only instantiated by uart_ack_framer when ACK_CRC_EN is defined.
// Ports:
//   clk_50M      - clock
//   rst_n        - asynchronous active-low reset (clears crc_out)
//   clear        - synchronous clear to the init value, wins over enable
//   enable       - fold data_in into the running CRC this cycle
//   data_in[7:0] - byte to fold in
//   crc_out[7:0] - running CRC value
module crc8_byte (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      crc_out <= 8'h00;
    end else if (clear) begin
      crc_out <= 8'h00;
    end else if (enable) begin
      crc_out <= crc8_next(crc_out, data_in);
    end
  end

endmodule

// File: rtl/uart_ack_framer.sv
// uart_ack_framer
// Builds a six-byte ack frame (HDR_BYTE, rev_data1..3, check byte,
// TAIL_BYTE) after each received command and feeds it byte by byte to a
// UART transmitter through a tx_en/tx_busy/tx_done handshake. A request
// arriving while a frame is in flight is parked in a one-deep pending slot;
// a further request while the slot is full is dropped.
// Build option: ACK_CRC_EN - when defined, the check byte is a CRC-8 over
// the three payload bytes; otherwise it is the constant CHK_DEFAULT.
// Ports:
//   clk_50M, rst_n          - clock, asynchronous active-low reset
//   recv_done               - one-cycle pulse, command packet received
//   rev_data1..3[7:0]       - payload to echo
//   tx_busy, tx_done        - transmitter status / byte-complete pulse
//   tx_en, tx_data[7:0]     - start strobe and byte to the transmitter
//   ack_busy                - frame in progress
//   ack_done, ack_drop      - frame finished / request discarded pulses
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a request (new or pending)
// DELAY     | START_DLY-cycle start delay; CRC built in its first cycles
// LOAD      | waiting for tx_busy low to launch frame[idx]
// WAIT_DONE | byte launched, waiting for tx_done
// GAP       | GAP_CYC+1 cycle spacing before the next byte
// FINISH    | pulse ack_done, drop ack_busy, back to IDLE
module uart_ack_framer
  import dds_uart_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE  = 8'h80,
  parameter logic [7:0]  TAIL_BYTE = 8'h55,
  parameter int unsigned START_DLY = 16,
  parameter int unsigned GAP_CYC   = 15
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       recv_done,
  input  logic [7:0] rev_data1,
  input  logic [7:0] rev_data2,
  input  logic [7:0] rev_data3,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       ack_busy,
  output logic       ack_done,
  output logic       ack_drop
);

  localparam logic [7:0] DLY_LOAD = 8'(START_DLY - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  logic [2:0] state;
  logic [2:0] idx;
  logic [7:0] dly_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] act_d1, act_d2, act_d3;
  logic       pend_vld;
  logic [7:0] pend_d1, pend_d2, pend_d3;
  logic [7:0] chk_byte;
  logic       start_frame;

  assign start_frame = (state == ST_IDLE) && (pend_vld || recv_done);

`ifdef ACK_CRC_EN
  logic       crc_en;
  logic [7:0] crc_data;
  logic [7:0] crc_val;

  // Payload bytes are folded in on the first three DELAY cycles, picked by
  // how far the delay counter has run down from its load value.
  assign crc_en = (state == ST_DELAY) && (dly_cnt >= (DLY_LOAD - 8'd2));

  always_comb begin
    crc_data = act_d3;
    if (dly_cnt == DLY_LOAD) begin
      crc_data = act_d1;
    end else if (dly_cnt == (DLY_LOAD - 8'd1)) begin
      crc_data = act_d2;
    end
  end

  crc8_byte u_crc8_byte (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .clear   (start_frame),
    .enable  (crc_en),
    .data_in (crc_data),
    .crc_out (crc_val)
  );

  assign chk_byte = crc_val;
`else
  assign chk_byte = CHK_DEFAULT;
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= 3'd0;
      dly_cnt  <= 8'd0;
      gap_cnt  <= 8'd0;
      act_d1   <= 8'h00;
      act_d2   <= 8'h00;
      act_d3   <= 8'h00;
      pend_vld <= 1'b0;
      pend_d1  <= 8'h00;
      pend_d2  <= 8'h00;
      pend_d3  <= 8'h00;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      ack_busy <= 1'b0;
      ack_done <= 1'b0;
      ack_drop <= 1'b0;
    end else begin
      tx_en    <= 1'b0;
      ack_done <= 1'b0;
      ack_drop <= 1'b0;

      // Pending slot. In IDLE with a full slot the slot drains into the
      // active snapshot this cycle, so a simultaneous request refills it.
      if (recv_done) begin
        if (state == ST_IDLE && !pend_vld) begin
          // taken straight into the active snapshot below
        end else if (state == ST_IDLE || !pend_vld) begin
          pend_vld <= 1'b1;
          pend_d1  <= rev_data1;
          pend_d2  <= rev_data2;
          pend_d3  <= rev_data3;
        end else begin
          ack_drop <= 1'b1;
        end
      end else if (state == ST_IDLE && pend_vld) begin
        pend_vld <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            if (pend_vld) begin
              act_d1 <= pend_d1;
              act_d2 <= pend_d2;
              act_d3 <= pend_d3;
            end else begin
              act_d1 <= rev_data1;
              act_d2 <= rev_data2;
              act_d3 <= rev_data3;
            end
            idx      <= 3'd0;
            dly_cnt  <= DLY_LOAD;
            ack_busy <= 1'b1;
            state    <= ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (dly_cnt == 8'd0) begin
            idx   <= 3'd0;
            state <= ST_LOAD;
          end else begin
            dly_cnt <= dly_cnt - 8'd1;
          end
        end

        ST_LOAD: begin
          if (idx > LAST_IDX) begin
            ack_busy <= 1'b0;
            idx      <= 3'd0;
            state    <= ST_IDLE;
          end else if (!tx_busy) begin
            tx_data <= frame_byte(idx, HDR_BYTE, act_d1, act_d2, act_d3, chk_byte, TAIL_BYTE);
            tx_en   <= 1'b1;
            state   <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (tx_done) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (idx < LAST_IDX) begin
            idx   <= idx + 3'd1;
            state <= ST_LOAD;
          end else if (idx == LAST_IDX) begin
            state <= ST_FINISH;
          end else begin
            ack_busy <= 1'b0;
            idx      <= 3'd0;
            state    <= ST_IDLE;
          end
        end

        ST_FINISH: begin
          ack_done <= 1'b1;
          ack_busy <= 1'b0;
          idx      <= 3'd0;
          state    <= ST_IDLE;
        end

        default: begin
          ack_busy <= 1'b0;
          idx      <= 3'd0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
